// File: rtl/dmem_pkg.sv
// dmem_pkg: shared state type and width helpers for the data memory controller
package dmem_pkg;
  typedef enum logic {ST_CLEAR, ST_IDLE} state_t;
  function automatic int be_w(input int dw);
    return dw / 8;
  endfunction
  function automatic int off_w(input int dw);
    return $clog2(dw / 8);
  endfunction
  function automatic int idx_w(input int depth);
    return $clog2(depth);
  endfunction
endpackage

// File: rtl/dmem_array.sv
// dmem_array: word storage with one byte-enabled write port and one registered read port
//  clock  in   posedge clock
//  we     in   write enable, be selects bytes of wdata written to word widx
//  ridx   in   read index, rdata valid the cycle after
//  tap    out  DMEM_TAP_EN only: low nibbles of words 7..0, combinational
module dmem_array #(
  parameter int DW = 32,
  parameter int DEPTH = 128,
  parameter int BE_W = DW / 8,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             we,
  input  logic [BE_W-1:0]  be,
  input  logic [IDX_W-1:0] widx,
  input  logic [DW-1:0]    wdata,
  input  logic [IDX_W-1:0] ridx,
  output logic [DW-1:0]    rdata
`ifdef DMEM_TAP_EN
  ,
  output logic [31:0]      tap
`endif
);
  logic [DW-1:0] mem [DEPTH];
  always_ff @(posedge clock) begin
    if (we)
      for (int b = 0; b < BE_W; b++)
        if (be[b]) mem[widx][8*b +: 8] <= wdata[8*b +: 8];
    rdata <= mem[ridx];
  end
`ifdef DMEM_TAP_EN
  for (genvar i = 0; i < 8; i++) begin : g_tap
    assign tap[4*i +: 4] = mem[i][3:0];
  end
`endif
endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: data memory with valid/ready requests, byte-enable writes and a hardware clear sweep
//  clock, reset      posedge clock, asynchronous active-low reset
//  clr               start a clear sweep (sampled in IDLE and CLEAR)
//  req_*             request port, accepted on req_valid && req_ready
//  rsp_valid         one-cycle response pulse, rsp_rdata / rsp_err valid with it, 0 otherwise
//  busy              clear sweep in progress
//  tap               present only when DMEM_TAP_EN is defined
module dmem_ctrl import dmem_pkg::*; #(
  parameter int DW = 32,
  parameter int DEPTH = 128,
  parameter int AW = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            clr,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [DW/8-1:0] req_be,
  input  logic [AW-1:0]   req_addr,
  input  logic [DW-1:0]   req_wdata,
  output logic            rsp_valid,
  output logic [DW-1:0]   rsp_rdata,
  output logic            rsp_err,
  output logic            busy
`ifdef DMEM_TAP_EN
  ,
  output logic [31:0]     tap
`endif
);
  localparam int BE_W = be_w(DW);
  localparam int OFF_W = off_w(DW);
  localparam int IDX_W = idx_w(DEPTH);
  state_t state;
  logic [IDX_W-1:0] ptr;
  logic [AW-1:0] word;
  logic err, acc, rd_ok, we;
  logic [BE_W-1:0] be;
  logic [IDX_W-1:0] widx;
  logic [DW-1:0] wdata, rdata;
  assign word = req_addr >> OFF_W;
  assign err = (word >= AW'(DEPTH)) || ((req_addr & AW'(BE_W - 1)) != '0);
  assign busy = state == ST_CLEAR;
  assign req_ready = state == ST_IDLE && !clr;
  assign acc = req_valid && req_ready;
  // the sweep owns the write port while busy; requests cannot be accepted then
  assign we = busy || (acc && req_we && !err);
  assign be = busy ? '1 : req_be;
  assign widx = busy ? ptr : word[IDX_W-1:0];
  assign wdata = busy ? '0 : req_wdata;
  assign rsp_rdata = rd_ok ? rdata : '0;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= ST_CLEAR;
      ptr <= '0;
      rsp_valid <= 1'b0;
      rsp_err <= 1'b0;
      rd_ok <= 1'b0;
    end else begin
      rsp_valid <= acc;
      rsp_err <= acc && err;
      rd_ok <= acc && !req_we && !err;
      if (clr) begin
        state <= ST_CLEAR;
        ptr <= '0;
      end else if (state == ST_CLEAR) begin
        ptr <= ptr + 1'b1;
        if (ptr == IDX_W'(DEPTH - 1)) state <= ST_IDLE;
      end
    end
  end
  dmem_array #(.DW(DW), .DEPTH(DEPTH), .BE_W(BE_W), .IDX_W(IDX_W)) u_array (
    .clock(clock),
    .we(we),
    .be(be),
    .widx(widx),
    .wdata(wdata),
    .ridx(word[IDX_W-1:0]),
    .rdata(rdata)
`ifdef DMEM_TAP_EN
    ,
    .tap(tap)
`endif
  );
endmodule
